// File: rtl/uart_write_arbiter.sv
// rtl/uart_write_arbiter.sv - per-thread UART write-lock arbiter feeding a TX byte FIFO
// Define UART_ARB_RR_EN for round-robin winner selection; otherwise fixed priority.
module uart_write_arbiter #(
  parameter int NTHREADS   = 2,
  parameter int FIFO_DEPTH = 16,
  parameter int FIFO_AW    = $clog2(FIFO_DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [NTHREADS-1:0]   write_lock_req,
  output logic [NTHREADS-1:0]   write_lock_res,
  output logic [NTHREADS-1:0]   write_ready,
  input  logic [8*NTHREADS-1:0] write_data,
  input  logic [NTHREADS-1:0]   write_data_valid,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [FIFO_AW:0]      fifo_level,
  output logic                  overflow
);

  localparam int IW = (NTHREADS > 1) ? $clog2(NTHREADS) : 1;
  localparam logic [FIFO_AW:0] DEPTH_L = (FIFO_AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {ARB_IDLE, ARB_GRANT, ARB_RELEASE} arb_state_t;

  arb_state_t        state, state_n;
  logic [IW-1:0]     owner, owner_n, rr_ptr, winner;
  logic              winner_found;
  logic [NTHREADS-1:0] grant_vec;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]  level;
  logic              full, empty, space_ok, push_req, push, pop;

`ifdef UART_ARB_RR_EN
  logic [IW-1:0] rr_n;

  always_comb begin
    rr_n = (int'(owner) == NTHREADS - 1) ? '0 : owner + IW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset)
      rr_ptr <= '0;
    else if (state == ARB_RELEASE)
      rr_ptr <= rr_n;
  end
`else
  assign rr_ptr = '0;
`endif

  // Scan from rr_ptr upward, wrapping; with fixed priority rr_ptr is 0.
  always_comb begin
    int idx;
    idx          = 0;
    winner_found = 1'b0;
    winner       = '0;
    for (int k = 0; k < NTHREADS; k++) begin
      idx = (int'(rr_ptr) + k) % NTHREADS;
      if (!winner_found && write_lock_req[idx]) begin
        winner_found = 1'b1;
        winner       = IW'(idx);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ARB_IDLE;
      owner <= '0;
    end else begin
      state <= state_n;
      owner <= owner_n;
    end
  end

  always_comb begin
    state_n = state;
    owner_n = owner;
    case (state)
      ARB_IDLE: begin
        if (winner_found) begin
          owner_n = winner;
          state_n = ARB_GRANT;
        end
      end
      ARB_GRANT: begin
        if (!write_lock_req[owner])
          state_n = ARB_RELEASE;
      end
      ARB_RELEASE: state_n = ARB_IDLE;
      default:     state_n = ARB_IDLE;
    endcase
  end

  assign grant_vec      = (state == ARB_GRANT) ? (NTHREADS'(1) << owner) : '0;
  assign write_lock_res = grant_vec;

  // Two free slots keep room for the byte already launched when ready drops.
  assign full     = (level == DEPTH_L);
  assign empty    = (level == '0);
  assign space_ok = ((DEPTH_L - level) >= (FIFO_AW+1)'(2));
  assign write_ready = space_ok ? grant_vec : '0;

  assign push_req = (state == ARB_GRANT) && write_data_valid[owner];
  assign pop      = !empty && tx_ready;
  assign push     = push_req && (!full || pop);

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= write_data[8*owner +: 8];
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)
        rd_ptr <= rd_ptr + FIFO_AW'(1);
      case ({push, pop})
        2'b10:   level <= level + (FIFO_AW+1)'(1);
        2'b01:   level <= level - (FIFO_AW+1)'(1);
        default: level <= level;
      endcase
      if (push_req && full && !pop)
        overflow <= 1'b1;
    end
  end

  assign tx_valid   = !empty;
  assign tx_data    = empty ? 8'h00 : mem[rd_ptr];
  assign fifo_level = level;

endmodule

// File: tb/tb_uart_write_arbiter.sv
// tb/tb_uart_write_arbiter.sv - directed self-checking bench for uart_write_arbiter
module tb_uart_write_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req, res, ready, valid;
  logic [15:0] wdata;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic [4:0]  fifo_level;
  logic        overflow;

  int errors = 0;
  int checks = 0;
  logic [7:0] rx_q [$];

  uart_write_arbiter #(.NTHREADS(2), .FIFO_DEPTH(16), .FIFO_AW(4)) dut (
    .clock(clock), .reset(reset),
    .write_lock_req(req), .write_lock_res(res), .write_ready(ready),
    .write_data(wdata), .write_data_valid(valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .fifo_level(fifo_level), .overflow(overflow)
  );

  always #5 clock = ~clock;

  always @(negedge clock)
    if (!reset && tx_valid && tx_ready) rx_q.push_back(tx_data);

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic check_rx(input string tag, input int n, input logic [7:0] base, input logic [7:0] b0);
    check_eq({tag, "_count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++)
      check_eq($sformatf("%s_byte%0d", tag, i), rx_q[i], (i == 0 && base == 8'h00) ? b0 : base + 8'(i));
  endtask

  logic [7:0] t1_bytes [5];
  logic       prev_ready;
  int         cnt;
  bit         seen_fall;

  initial begin
    t1_bytes = '{8'h05, 8'h00, 8'h00, 8'h00, 8'hAB};
    reset = 1'b1; req = '0; valid = '0; wdata = '0; tx_ready = 1'b1;
    tick(); tick();
    check_eq("rst_res", res, 0);
    check_eq("rst_ready", ready, 0);
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_level", fifo_level, 0);
    check_eq("rst_overflow", overflow, 0);
    reset = 1'b0;

    // 1: single thread, stream with tx_ready high
    req = 2'b01;
    tick();
    check_eq("t1_res", res, 2'b01);
    check_eq("t1_ready", ready, 2'b01);
    for (int i = 0; i < 5; i++) begin
      valid = 2'b01; wdata = {8'h00, t1_bytes[i]};
      tick();
    end
    valid = '0;
    repeat (5) tick();
    check_eq("t1_count", rx_q.size(), 5);
    for (int i = 0; i < 5 && i < rx_q.size(); i++)
      check_eq($sformatf("t1_byte%0d", i), rx_q[i], t1_bytes[i]);
    req = '0;
    tick();
    check_eq("t1_release_res", res, 0);
    tick();

    // 2: backpressure, thread launches one cycle after sampling ready
    rx_q.delete();
    tx_ready = 1'b0;
    req = 2'b01;
    tick();
    prev_ready = 1'b0; cnt = 0; seen_fall = 0;
    for (int i = 0; i < 25; i++) begin
      if (!ready[0] && !seen_fall) begin
        seen_fall = 1;
        check_eq("t2_ready_fall_level", fifo_level, 15);
      end
      valid = {1'b0, prev_ready};
      wdata = {8'h00, 8'h40 + 8'(cnt)};
      if (prev_ready) cnt++;
      prev_ready = ready[0];
      tick();
    end
    valid = '0;
    check_eq("t2_ready_fell", seen_fall, 1);
    check_eq("t2_pushed", cnt, 16);
    check_eq("t2_level_full", fifo_level, 16);
    check_eq("t2_overflow", overflow, 0);
    check_eq("t2_ready_full", ready, 0);
    req = '0;
    tx_ready = 1'b1;
    repeat (20) tick();
    check_rx("t2", 16, 8'h40, 8'h40);
    check_eq("t2_level_empty", fifo_level, 0);

    // 3/4: contention from reset
    reset = 1'b1; req = 2'b11; tx_ready = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    check_eq("t3_first_grant", res, 2'b01);
    tick();
    req = 2'b10;
    tick();
    check_eq("t3_release_gap", res, 2'b00);
    req = 2'b11;
    tick();
    check_eq("t3_idle_gap", res, 2'b00);
    tick();
`ifdef UART_ARB_RR_EN
    check_eq("t3_second_grant", res, 2'b10);
    check_eq("t3_second_ready", ready, 2'b10);
    valid = 2'b01; wdata = 16'h0077;
    tick();
    valid = '0;
    check_eq("t3_nongranted_ignored", fifo_level, 0);
    check_eq("t3_no_preempt", res, 2'b10);
`else
    check_eq("t4_second_grant", res, 2'b01);
    check_eq("t4_second_ready", ready, 2'b01);
    valid = 2'b10; wdata = 16'h7700;
    tick();
    valid = '0;
    check_eq("t4_nongranted_ignored", fifo_level, 0);
    check_eq("t4_hold", res, 2'b01);
`endif
    req = '0;
    repeat (3) tick();

    // 5: overflow
    reset = 1'b1;
    tick();
    reset = 1'b0; rx_q.delete();
    req = 2'b01;
    tick();
    for (int i = 0; i < 18; i++) begin
      valid = 2'b01; wdata = {8'h00, 8'(i)};
      tick();
    end
    valid = '0;
    check_eq("t5_level", fifo_level, 16);
    check_eq("t5_overflow", overflow, 1);
    check_eq("t5_head", tx_data, 8'h00);
    valid = 2'b01; wdata = 16'h00EE; tx_ready = 1'b1;
    tick();
    valid = '0; tx_ready = 1'b0;
    check_eq("t5_full_pushpop_level", fifo_level, 16);
    check_eq("t5_overflow_sticky", overflow, 1);
    check_eq("t5_head_after_pop", tx_data, 8'h01);
    tx_ready = 1'b1;
    repeat (11) tick();
    tx_ready = 1'b0;
    check_eq("t6_level_before", fifo_level, 5);
    check_eq("t6_head_before", tx_data, 8'h0C);

    // 6: reset mid-grant
    reset = 1'b1;
    tick();
    check_eq("t6_res", res, 0);
    check_eq("t6_tx_valid", tx_valid, 0);
    check_eq("t6_level", fifo_level, 0);
    check_eq("t6_overflow", overflow, 0);
    check_eq("t6_ready", ready, 0);
    reset = 1'b0; req = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
